rr_xy_allocator: RTL
====================

Name: rr_xy_allocator

Overview:
- Connection allocator for the 5-port Phoenix router. Arbitrates header requests from the input buffers round-robin and computes the XY output port from the header flit.
- Grants a free output, drives the crossbar mux tables, and releases connections when the input buffer stops sending.
- Sits between the input buffers (h/ack_h/sender) and the crossbar (free, mux tables).

Parameters:
- NPORT, 5, number of ports; encoding EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- TAM_FLIT, 16, flit width in bits.
- ADDRESS, 8'h11, router address; X in [7:4], Y in [3:0].

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst  input  1  asynchronous, active-low reset.
- i_h  input  NPORT  header-pending request per input buffer.
- o_ack_h  output  NPORT  one-cycle header grant per input.
- i_data  input  NPORT*TAM_FLIT  buffer head flits; port p at [p*TAM_FLIT +: TAM_FLIT].
- i_sender  input  NPORT  input p is transmitting a packet.
- o_free  output  NPORT  output port p unallocated.
- o_mux_in  output  NPORT*3  per output: source input index, at [p*3 +: 3].
- o_mux_out  output  NPORT*3  per input: destination output index, at [p*3 +: 3].

Behaviour:
- Reset (i_rst=0, async): state IDLE, o_ack_h=0, o_free=5'b11111, o_mux_in=0, o_mux_out=0, conn_valid=0, sender_q=0, rr_ptr=LOCAL (first search starts at EAST).
- All outputs registered. FSM is IDLE -> ARB -> ROUTE -> GRANT -> IDLE.
- IDLE: any i_h set -> ARB; otherwise stay.
- ARB: sel = first p with i_h[p]=1, searching (rr_ptr+1) mod 5 upward with wrap. Latch sel; rr_ptr<=sel; -> ROUTE. If i_h is all 0 -> IDLE.
- ROUTE: read tx=i_data[sel][7:4], ty=i_data[sel][3:0]; lx=ADDRESS[7:4], ly=ADDRESS[3:0].
  - dest = EAST if tx>lx; WEST if tx<lx; else NORTH if ty>ly; SOUTH if ty<ly; else LOCAL.
  - Comparisons are unsigned 4-bit.
  - If i_h[sel]=0 -> IDLE with no grant.
  - If o_free[dest]=0 -> IDLE with no grant; rr_ptr is already advanced, so other requesters are served next.
  - Otherwise latch dest -> GRANT.
- GRANT (exactly one cycle): o_ack_h[sel]=1; o_free[dest]<=0; o_mux_in[dest]<=sel; o_mux_out[sel]<=dest; conn_valid[sel]<=1; -> IDLE.
- o_ack_h is one-hot or zero and never high for two consecutive cycles.
- Latency: i_h first sampled high in IDLE at edge k -> o_ack_h high after edge k+3, provided the output is free.
- Release, every cycle independent of FSM: sender_q<=i_sender. For each p with conn_valid[p]=1, sender_q[p]=1 and i_sender[p]=0 (falling edge):
  - o_free[o_mux_out[p]]<=1 and conn_valid[p]<=0 on the next edge.
  - o_mux_in and o_mux_out keep stale values after release.
- Simultaneous release and grant in one cycle: both apply. They never target the same output, because a granted dest was free.
- Multiple releases in the same cycle are all applied.
- U-turn (dest==sel, non-LOCAL) is granted like any other route; correct XY traffic never produces it.
- Reset mid-operation (any state, including GRANT) returns immediately to reset values. A pending ack is dropped.

Test Plan:
1. Reset with ADDRESS=8'h11 -> o_free=5'b11111, o_ack_h=0, mux tables 0. No ack while i_h=0 over 20 cycles.
2. i_h[LOCAL]=1 with head flit 16'h0021 -> o_ack_h=5'b10000 exactly 3 cycles later for 1 cycle. Then o_free[EAST]=0, o_mux_in[EAST]=3'd4, o_mux_out[LOCAL]=3'd0.
3. i_h[WEST] and i_h[NORTH] set together, headers 16'h0011 and 16'h0010 -> first grant WEST->LOCAL. NORTH->SOUTH is granted on the next arbitration pass. The two acks are never in the same cycle.
4. LOCAL holds EAST; i_h[NORTH] with header 16'h0031 -> no ack while EAST busy. Then drop i_sender[LOCAL] 1->0 -> o_free[EAST]=1 next cycle, and NORTH is acked within 4 cycles.
5. Round-robin fairness: i_h=5'b11111 held, all headers 16'h0011, i_sender pulsed 1 then 0 after each ack so LOCAL frees -> ack order EAST, WEST, NORTH, SOUTH, LOCAL, EAST.
6. Assert i_rst=0 during the GRANT cycle -> o_ack_h=0 immediately, o_free=5'b11111. No ack appears until i_h is re-sampled after reset release.

Source files
------------

// File: rtl/rr_xy_allocator.sv
// Connection allocator for a 5-port XY router.
// Picks one pending header request round-robin, works out its XY output
// port, grants it if that output is free, and drives the crossbar mux tables.
// A connection is torn down when its input buffer stops sending.
module rr_xy_allocator #(
  parameter int unsigned NPORT    = 5,
  parameter int unsigned TAM_FLIT = 16,
  parameter logic [7:0]  ADDRESS  = 8'h11
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NPORT-1:0]          i_h,
  output logic [NPORT-1:0]          o_ack_h,
  input  logic [NPORT*TAM_FLIT-1:0] i_data,
  input  logic [NPORT-1:0]          i_sender,
  output logic [NPORT-1:0]          o_free,
  output logic [NPORT*3-1:0]        o_mux_in,
  output logic [NPORT*3-1:0]        o_mux_out
);

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  localparam logic [3:0] LX = ADDRESS[7:4];
  localparam logic [3:0] LY = ADDRESS[3:0];

  typedef enum logic [1:0] {StIdle, StArb, StRoute, StGrant} state_e;

  state_e             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         dest_q, dest_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [NPORT-1:0]   ack_q, ack_d;
  logic [NPORT-1:0]   free_q, free_d;
  logic [NPORT-1:0]   conn_valid_q, conn_valid_d;
  logic [NPORT-1:0]   sender_q;
  logic [2:0]         mux_in_q [NPORT];
  logic [2:0]         mux_in_d [NPORT];
  logic [2:0]         mux_out_q [NPORT];
  logic [2:0]         mux_out_d [NPORT];

  logic [TAM_FLIT-1:0] flit [NPORT];
  logic                arb_found;
  logic [2:0]          arb_sel;
  logic [2:0]          route_dest;
  logic                grant;
  logic [NPORT-1:0]    release_req;

  // Unpack the flat buses into per-port views.
  for (genvar gp = 0; gp < NPORT; gp++) begin : g_port
    assign flit[gp]             = i_data[gp*TAM_FLIT +: TAM_FLIT];
    assign o_mux_in[gp*3 +: 3]  = mux_in_q[gp];
    assign o_mux_out[gp*3 +: 3] = mux_out_q[gp];
  end

  assign o_ack_h = ack_q;
  assign o_free  = free_q;

  // Round-robin search: first requester strictly after rr_ptr, wrapping.
  always_comb begin
    int unsigned cand;
    logic [2:0]  cand_idx;
    arb_found = 1'b0;
    arb_sel   = rr_ptr_q;
    for (int unsigned off = 1; off <= NPORT; off++) begin
      cand     = (32'(rr_ptr_q) + off) % NPORT;
      cand_idx = cand[2:0];
      if (!arb_found && i_h[cand_idx]) begin
        arb_found = 1'b1;
        arb_sel   = cand_idx;
      end
    end
  end

  // XY routing: resolve X first, then Y, else deliver locally.
  always_comb begin
    logic [TAM_FLIT-1:0] head;
    logic [3:0]          tx;
    logic [3:0]          ty;
    head = flit[sel_q];
    tx   = head[7:4];
    ty   = head[3:0];
    if (tx > LX)      route_dest = EAST;
    else if (tx < LX) route_dest = WEST;
    else if (ty > LY) route_dest = NORTH;
    else if (ty < LY) route_dest = SOUTH;
    else              route_dest = LOCAL;
  end

  // Allocation FSM next-state.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dest_d   = dest_q;
    rr_ptr_d = rr_ptr_q;
    grant    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|i_h) state_d = StArb;
      end
      StArb: begin
        if (arb_found) begin
          sel_d    = arb_sel;
          rr_ptr_d = arb_sel;
          state_d  = StRoute;
        end else begin
          state_d = StIdle;
        end
      end
      StRoute: begin
        // Request withdrawn or output busy: give up; rr_ptr already moved on.
        if (!i_h[sel_q] || !free_q[route_dest]) begin
          state_d = StIdle;
        end else begin
          dest_d  = route_dest;
          state_d = StGrant;
        end
      end
      StGrant: begin
        grant   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Release detection: an active connection whose sender just dropped.
  always_comb begin
    release_req = conn_valid_q & sender_q & ~i_sender;
  end

  // Connection table update: releases and a grant can land together.
  always_comb begin
    ack_d        = '0;
    free_d       = free_q;
    conn_valid_d = conn_valid_q & ~release_req;
    mux_in_d     = mux_in_q;
    mux_out_d    = mux_out_q;
    for (int p = 0; p < NPORT; p++) begin
      if (release_req[p]) free_d[mux_out_q[p]] = 1'b1;
    end
    // A granted dest was free, so it never collides with a release target.
    if (grant) begin
      ack_d[sel_q]        = 1'b1;
      free_d[dest_q]      = 1'b0;
      mux_in_d[dest_q]    = sel_q;
      mux_out_d[sel_q]    = dest_q;
      conn_valid_d[sel_q] = 1'b1;
    end
  end

  // State and table registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      dest_q       <= '0;
      rr_ptr_q     <= LOCAL;
      ack_q        <= '0;
      free_q       <= '1;
      conn_valid_q <= '0;
      sender_q     <= '0;
      for (int i = 0; i < NPORT; i++) begin
        mux_in_q[i]  <= '0;
        mux_out_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      dest_q       <= dest_d;
      rr_ptr_q     <= rr_ptr_d;
      ack_q        <= ack_d;
      free_q       <= free_d;
      conn_valid_q <= conn_valid_d;
      sender_q     <= i_sender;
      for (int i = 0; i < NPORT; i++) begin
        mux_in_q[i]  <= mux_in_d[i];
        mux_out_q[i] <= mux_out_d[i];
      end
    end
  end

endmodule
